// File: rtl/spi_frame_receiver.sv
// +--------------------------------------------------------------------------+
// | spi_frame_receiver : mode-0 SPI slave frame capture into a show-ahead FIFO |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module spi_frame_receiver #(
  parameter int unsigned FRAME_BITS = 24,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spi_clock,
  input  logic                          spi_data,
  input  logic                          cs_n,
  output logic [FRAME_BITS-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_err
);

  localparam int unsigned          c_addr_w   = $clog2(FIFO_DEPTH);
  localparam int unsigned          c_cnt_w    = $clog2(FRAME_BITS + 2);
  localparam logic [c_cnt_w-1:0]   c_cnt_full = c_cnt_w'(FRAME_BITS);
  localparam logic [c_cnt_w-1:0]   c_cnt_sat  = c_cnt_w'(FRAME_BITS + 1);
  localparam logic [c_addr_w:0]    c_depth    = (c_addr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_SHIFT    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             sclk_sync_q, data_sync_q, cs_sync_q;
  logic [1:0]             prime_q;
  logic [c_cnt_w-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [c_addr_w-1:0]    wr_ptr_q, rd_ptr_q;
  logic [c_addr_w:0]      count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q;
  logic [FRAME_BITS-1:0]  mem_q [FIFO_DEPTH];

  logic w_sclk_rise, w_cs_fall, w_cs_rise, w_sample, w_eval;
  logic w_frame_ok, w_frame_bad, w_full, w_pop, w_push, w_drop;

  // Stage [1] is the synchronized level, stage [2] its one-clk-old copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= 3'b111;
      data_sync_q <= 3'b111;
      cs_sync_q   <= 3'b111;
      prime_q     <= 2'b00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clock};
      data_sync_q <= {data_sync_q[1:0], spi_data};
      cs_sync_q   <= {cs_sync_q[1:0], cs_n};
      prime_q     <= {prime_q[0], 1'b1};
    end
  end

  assign w_sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign w_cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign w_cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

  // Arming waits for prime_q so the reset value of the synchronizer is never
  // mistaken for a real cs_n-high observation.
  always_comb begin
    state_d = state_q;
    w_eval  = 1'b0;
    case (state_q)
      ST_DISARMED: if (prime_q[1] && cs_sync_q[1]) state_d = ST_IDLE;
      ST_IDLE:     if (w_cs_fall) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (w_cs_rise) begin
          state_d = ST_IDLE;
          w_eval  = 1'b1;
        end
      end
      default:     state_d = ST_DISARMED;
    endcase
  end

  // Data is taken from stage [2]; it settled long before the clock edge.
  assign w_sample = (state_q == ST_SHIFT) && !cs_sync_q[1] && w_sclk_rise;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (w_cs_fall) begin
      bit_cnt_d = '0;
    end else if (w_sample && (bit_cnt_q != c_cnt_sat)) begin
      bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
    end
    if (w_sample) begin
      shift_d = {shift_q[FRAME_BITS-2:0], data_sync_q[2]};
    end
  end

  assign w_frame_ok  = w_eval && (bit_cnt_q == c_cnt_full);
  assign w_frame_bad = w_eval && (bit_cnt_q != c_cnt_full);
  assign w_full      = (count_q == c_depth);
  assign w_pop       = rx_valid && rx_ready;
  assign w_push      = w_frame_ok && (!w_full || w_pop);
  assign w_drop      = w_frame_ok && w_full && !w_pop;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (c_addr_w + 1)'(1);
      2'b01:   count_d = count_q - (c_addr_w + 1)'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DISARMED;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= w_frame_bad;
      if (w_push) wr_ptr_q <= wr_ptr_q + c_addr_w'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_addr_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign busy       = (state_q == ST_SHIFT);
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_receiver.sv
// +--------------------------------------------------------------------------+
// | tb_spi_frame_receiver : scoreboard bench for spi_frame_receiver           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_spi_frame_receiver;

  localparam int FB    = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_clock = 1'b0;
  logic          spi_data = 1'b0;
  logic          cs_n = 1'b1;
  logic          rx_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [FB-1:0] rx_data;
  logic          rx_valid;
  logic [2:0]    fifo_count;
  logic          busy, frame_err, overflow;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [FB-1:0] exp_q[$];
  bit            ov_m = 1'b0;

  spi_frame_receiver #(.FRAME_BITS(FB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clock  (spi_clock),
    .spi_data   (spi_data),
    .cs_n       (cs_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted pop must deliver the oldest stored word.
  always @(negedge clk) begin
    if (!rst && rx_valid === 1'b1 && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_order: got 0x%0h expected no word", rx_data);
      end else begin
        check("pop_order", {8'h0, rx_data}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    spi_data = b;
    wait_clk(10);
    spi_clock = 1'b1;
    wait_clk(10);
    spi_clock = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits,
                            input bit pop_on_push, input bit clr_on_end);
    bit good, full, accept;
    cs_n = 1'b0;
    wait_clk(10);
    check("busy_in_frame", {31'h0, busy}, 32'h1);
    for (int i = 0; i < nbits; i++) send_bit(val[nbits-1-i]);
    wait_clk(10);
    good   = (nbits == FB);
    full   = (exp_q.size() == DEPTH);
    accept = good && (!full || pop_on_push);
    cs_n = 1'b1;
    wait_clk(2);
    if (pop_on_push) rx_ready = 1'b1;
    if (clr_on_end)  clr_err  = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    clr_err  = 1'b0;
    if (accept) exp_q.push_back(val[FB-1:0]);
    if (good && !accept) ov_m = 1'b1;
    else if (clr_on_end) ov_m = 1'b0;
    check("frame_err_pulse", {31'h0, frame_err}, {31'h0, !good});
    check("overflow", {31'h0, overflow}, {31'h0, ov_m});
    check("fifo_count", {29'h0, fifo_count}, exp_q.size());
    check("rx_valid", {31'h0, rx_valid}, {31'h0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("head_word", {8'h0, rx_data}, {8'h0, exp_q[0]});
    wait_clk(1);
    check("frame_err_end", {31'h0, frame_err}, 32'h0);
    wait_clk(8);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rx_ready = 1'b1;
      wait_clk(1);
      rx_ready = 1'b0;
      wait_clk(1);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    ov_m = 1'b0;
    check("overflow_cleared", {31'h0, overflow}, 32'h0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nbits, r;
    wait_clk(3);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_rx_data", {8'h0, rx_data}, 32'h0);
    check("rst_fifo_count", {29'h0, fifo_count}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    rst = 1'b0;
    wait_clk(10);
    check("idle_busy", {31'h0, busy}, 32'h0);

    send_frame(32'h55AA12, 24, 0, 0);
    send_frame(32'h123456, 24, 0, 0);
    send_frame(32'hABCDEF, 24, 0, 0);
    send_frame(32'h000001, 24, 0, 0);
    check("fill_count", {29'h0, fifo_count}, 32'd4);
    pop_n(4);
    check("drained_count", {29'h0, fifo_count}, 32'd0);

    rx_ready = 1'b1;
    wait_clk(3);
    rx_ready = 1'b0;
    check("empty_pop_ignored", {29'h0, fifo_count}, 32'd0);

    send_frame(32'h55AA12, 24, 0, 0);
    send_frame(32'h123456, 24, 0, 0);
    send_frame(32'hABCDEF, 24, 0, 0);
    send_frame(32'h000001, 24, 0, 0);
    send_frame(32'hFFFFFF, 24, 0, 0);
    check("ovf_head", {8'h0, rx_data}, 32'h55AA12);
    pulse_clr();
    send_frame(32'hFFFFFF, 24, 0, 1);
    pulse_clr();
    send_frame(32'h777777, 24, 1, 0);
    pop_n(4);

    send_frame(32'h13579B, 24, 0, 0);
    send_frame($urandom, 23, 0, 0);
    send_frame($urandom, 25, 0, 0);
    send_frame(32'h0, 0, 0, 0);
    pop_n(1);

    cs_n = 1'b0;
    wait_clk(10);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    rst = 1'b1;
    exp_q.delete();
    ov_m = 1'b0;
    wait_clk(2);
    check("midrst_count", {29'h0, fifo_count}, 32'd0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    wait_clk(2);
    for (int i = 0; i < 14; i++) send_bit(1'($urandom));
    check("disarmed_busy", {31'h0, busy}, 32'h0);
    wait_clk(10);
    cs_n = 1'b1;
    wait_clk(5);
    check("disarmed_count", {29'h0, fifo_count}, 32'd0);
    check("disarmed_valid", {31'h0, rx_valid}, 32'h0);
    wait_clk(10);
    send_frame(32'h0F0F0F, 24, 0, 0);
    check("post_rst_word", {8'h0, rx_data}, 32'h0F0F0F);
    pop_n(1);

    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 9);
      nbits = (r < 6) ? 24 : (r == 6) ? 23 : (r == 7) ? 25 : $urandom_range(0, 30);
      send_frame($urandom, nbits, ($urandom_range(0, 3) == 0) && (exp_q.size() != 0),
                 $urandom_range(0, 5) == 0);
      pop_n($urandom_range(0, 2));
    end
    pop_n(exp_q.size());
    check("final_count", {29'h0, fifo_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_frame_receiver.md
SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 24, meaning the number of bits per SPI frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of frame words buffered; it is a power of two, 2 or greater.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port spi_clock  input  1  SPI serial clock from the master; asynchronous to clk.
REQ-006 SHALL have port spi_data  input  1  SPI serial data, MSB first; asynchronous to clk.
REQ-007 SHALL have port cs_n  input  1  active-low frame select; asynchronous to clk.
REQ-008 SHALL have port rx_data  output  FRAME_BITS  head-of-FIFO frame word (show-ahead).
REQ-009 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-010 SHALL have port rx_ready  input  1  consumer pop request.
REQ-011 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  number of stored words.
REQ-012 SHALL have port busy  output  1  frame in progress (synchronized cs_n low while armed).
REQ-013 SHALL have port frame_err  output  1  one-clk pulse when a frame ends with a bit count other than FRAME_BITS.
REQ-014 SHALL have port overflow  output  1  sticky flag: a complete frame was dropped because the FIFO was full.
REQ-015 SHALL have port clr_err  input  1  synchronous clear of overflow.

Function
REQ-016 SHALL pass spi_clock, spi_data and cs_n each through a 2-FF synchronizer, followed by a third register for edge detection.
REQ-017 SHALL sample synchronized spi_data on each detected rising edge of synchronized spi_clock (SPI mode 0) while synchronized cs_n is low and the receiver is armed.
REQ-018 SHALL shift each sampled bit into the LSB of a FRAME_BITS shift register, so the first bit received ends up as the MSB.
REQ-019 SHALL count sampled bits in a saturating counter that caps at FRAME_BITS+1 and clears on each detected cs_n falling edge.
REQ-020 SHALL handle a detected cs_n rising edge with a bit count equal to FRAME_BITS by pushing the shift register into the FIFO, or by setting overflow and dropping the word if the FIFO is full.
REQ-021 SHALL handle a detected cs_n rising edge with a bit count not equal to FRAME_BITS (including 0, fewer, or more bits) by pulsing frame_err for one clk, pushing nothing, and leaving overflow unchanged.
REQ-022 SHALL set rx_valid high on the clk edge that performs the push, which is the 3rd rising clk edge after cs_n is first sampled high.
REQ-023 SHALL pop the head word when rx_valid and rx_ready are both high, with rx_data updating on that same edge.
REQ-024 SHALL ignore rx_ready while the FIFO is empty.
REQ-025 SHALL perform both operations when a push and a pop occur in the same cycle, leaving fifo_count unchanged; a push into a full FIFO with a simultaneous pop succeeds and does not set overflow.
REQ-026 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-027 SHALL give clr_err lower priority than an overflow event in the same cycle, so overflow stays 1.
REQ-028 SHALL use a state machine with the following states and transitions:
- DISARMED: move to IDLE when synchronized cs_n is high.
- IDLE: move to SHIFT on a cs_n falling edge.
- SHIFT: move to IDLE on a cs_n rising edge, performing the REQ-020 or REQ-021 evaluation.
REQ-029 SHALL drive busy high only in SHIFT.
REQ-030 SHALL rely on the environment to hold spi_clock high and low phases for at least 3 clk periods each; behaviour under faster spi_clock is undefined.

Reset
REQ-031 SHALL, while rst is high, force the following values: state DISARMED, FIFO empty, fifo_count=0, rx_valid=0, rx_data=0, busy=0, frame_err=0, overflow=0, synchronizers=1, bit counter=0.
REQ-032 SHALL discard a partial frame when reset is asserted mid-frame, and SHALL accept no frame until cs_n has been seen high after rst deasserts.

Verification
REQ-033 SHALL be verified with a single frame: 24 bits 0x55AA12 sent with spi_clock at 200 ns per bit -> rx_valid=1 and rx_data=0x55AA12 within 3 clk of cs_n rising, fifo_count=1, frame_err=0.
REQ-034 SHALL be verified with a FIFO fill: frames 0x55AA12, 0x123456, 0xABCDEF, 0x000001 sent with rx_ready=0 -> fifo_count=4, then 4 pops return the words in that order and fifo_count=0.
REQ-035 SHALL be verified for overflow: a 5th frame 0xFFFFFF is sent with the FIFO full -> overflow=1 and the head word is still 0x55AA12; a clr_err pulse then gives overflow=0.
REQ-036 SHALL be verified for length errors: a 23-bit frame, and separately a 25-bit frame -> one frame_err pulse each and fifo_count unchanged.
REQ-037 SHALL be verified for reset mid-frame: rst is pulsed after 10 bits with cs_n held low -> nothing is pushed; after cs_n rises and a clean frame 0x0F0F0F is sent, rx_data=0x0F0F0F.
REQ-038 SHALL be verified for simultaneous push and pop: with fifo_count=4, rx_ready is held high on the push edge -> fifo_count stays 4, overflow=0, and the new word is at the tail.
